// File: rtl/stack.sv
// ---------------------------------------------------------------------------
// stack -- LIFO of {x,y} pairs with overflow/underflow/illegal detection.
//
// Parameters:
//   DEPTH : number of entries (2..256)
//   XW    : width of the x field
//   YW    : width of the y field
//
// Ports:
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset (clears count, outputs and fail)
//   push  : push request, writes {xIn,yIn} on top of the stack
//   pop   : pop request, loads top entry into xOut/yOut on the next cycle
//   xIn   : x field of the entry to push
//   yIn   : y field of the entry to push
//   xOut  : registered x field of the last popped entry
//   yOut  : registered y field of the last popped entry
//   fail  : registered illegal-operation flag
//   empty : combinational, count == 0
//   full  : combinational, count == DEPTH
//   count : registered number of stored entries
//
// Optional feature macro: STACK_STICKY_FAIL_EN
//   undefined : fail pulses for one cycle after each illegal request
//   defined   : fail stays high after the first illegal request until rst
// ---------------------------------------------------------------------------
module stack #(
  parameter int DEPTH = 16,
  parameter int XW    = 4,
  parameter int YW    = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic                           pop,
  input  logic [XW-1:0]                  xIn,
  input  logic [YW-1:0]                  yIn,
  output logic [XW-1:0]                  xOut,
  output logic [YW-1:0]                  yOut,
  output logic                           fail,
  output logic                           empty,
  output logic                           full,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = XW + YW;

  logic [EW-1:0] mem_r [DEPTH];
  logic [CW-1:0] count_r;
  logic [XW-1:0] x_out_r;
  logic [YW-1:0] y_out_r;
  logic          fail_r;

  logic          empty_s;
  logic          full_s;
  logic          push_ok_s;
  logic          pop_ok_s;
  logic          illegal_s;
  logic          fail_next_s;
  logic [AW-1:0] wr_idx_s;
  logic [AW-1:0] top_idx_s;
  logic [EW-1:0] top_entry_s;

  assign empty_s = (count_r == {CW{1'b0}});
  assign full_s  = (count_r == CW'(DEPTH));

  // Push writes at index count; pop reads the entry just below it.
  assign wr_idx_s    = count_r[AW-1:0];
  assign top_idx_s   = AW'(count_r - CW'(1));
  assign top_entry_s = mem_r[top_idx_s];

  // Classify the request: accepted push, accepted pop, or illegal.
  always_comb begin
    push_ok_s = 1'b0;
    pop_ok_s  = 1'b0;
    illegal_s = 1'b0;
    if (push && pop) begin
      illegal_s = 1'b1;
    end else if (push) begin
      if (full_s) begin
        illegal_s = 1'b1;
      end else begin
        push_ok_s = 1'b1;
      end
    end else if (pop) begin
      if (empty_s) begin
        illegal_s = 1'b1;
      end else begin
        pop_ok_s = 1'b1;
      end
    end else begin
      illegal_s = 1'b0;
    end
  end

  // Next value of the fail flag: pulse per illegal edge, or latch until reset.
  always_comb begin
    fail_next_s = 1'b0;
`ifdef STACK_STICKY_FAIL_EN
    fail_next_s = fail_r | illegal_s;
`else
    fail_next_s = illegal_s;
`endif
  end

  // Entry storage; not reset, since entries above count are never observable.
  always_ff @(posedge clk) begin
    if (!rst && push_ok_s) begin
      mem_r[wr_idx_s] <= {xIn, yIn};
    end
  end

  // Stack pointer, popped-data outputs and fail flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {CW{1'b0}};
      x_out_r <= {XW{1'b0}};
      y_out_r <= {YW{1'b0}};
      fail_r  <= 1'b0;
    end else begin
      fail_r <= fail_next_s;
      if (push_ok_s) begin
        count_r <= count_r + CW'(1);
      end else if (pop_ok_s) begin
        count_r <= count_r - CW'(1);
        x_out_r <= top_entry_s[EW-1:YW];
        y_out_r <= top_entry_s[YW-1:0];
      end else begin
        count_r <= count_r;
      end
    end
  end

  assign xOut  = x_out_r;
  assign yOut  = y_out_r;
  assign fail  = fail_r;
  assign empty = empty_s;
  assign full  = full_s;
  assign count = count_r;

endmodule

// File: tb/tb_stack.sv
// ---------------------------------------------------------------------------
// tb_stack -- self-checking bench for stack (DEPTH=16, XW=YW=4).
// Table of directed vectors plus hand-written sequences for fill/drain and
// the fail-flag behaviour. Expected fail values are written in pulse form;
// when STACK_STICKY_FAIL_EN is defined they are accumulated until reset.
// ---------------------------------------------------------------------------
module tb_stack;

  logic       clk;
  logic       rst;
  logic       push;
  logic       pop;
  logic [3:0] x_in;
  logic [3:0] y_in;
  logic [3:0] x_out;
  logic [3:0] y_out;
  logic       fail;
  logic       empty;
  logic       full;
  logic [4:0] count;

  int checks   = 0;
  int failures = 0;
  logic last_rst = 1'b0;
  logic sticky_acc = 1'b0;

  stack #(.DEPTH(16), .XW(4), .YW(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .xIn   (x_in),
    .yIn   (y_in),
    .xOut  (x_out),
    .yOut  (y_out),
    .fail  (fail),
    .empty (empty),
    .full  (full),
    .count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       push;
    logic       pop;
    logic [3:0] x;
    logic [3:0] y;
    logic [4:0] e_count;
    logic [3:0] e_x;
    logic [3:0] e_y;
    logic       e_fail;
    logic       e_empty;
    logic       e_full;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input logic r, input logic pu, input logic po,
                      input logic [3:0] x, input logic [3:0] y);
    rst  = r;
    push = pu;
    pop  = po;
    x_in = x;
    y_in = y;
    @(posedge clk);
    #1;
    last_rst = r;
  endtask

  task automatic check_all(input string tag, input int c, input int ex, input int ey,
                           input logic f_pulse, input logic e, input logic fu);
    logic f_exp;
`ifdef STACK_STICKY_FAIL_EN
    if (last_rst) sticky_acc = 1'b0;
    else          sticky_acc = sticky_acc | f_pulse;
    f_exp = sticky_acc;
`else
    f_exp = f_pulse;
`endif
    chk({tag, ".count"}, int'(count), c);
    chk({tag, ".xOut"},  int'(x_out), ex);
    chk({tag, ".yOut"},  int'(y_out), ey);
    chk({tag, ".fail"},  int'(fail),  int'(f_exp));
    chk({tag, ".empty"}, int'(empty), int'(e));
    chk({tag, ".full"},  int'(full),  int'(fu));
  endtask

  initial begin
    rst = 1'b1; push = 1'b0; pop = 1'b0; x_in = 4'd0; y_in = 4'd0;

    //           rst   push  pop   x      y      cnt    xo     yo     fail  empty full
    vq.push_back('{1'b1, 1'b0, 1'b0, 4'd0,  4'd0,  5'd0, 4'd0,  4'd0,  1'b0, 1'b1, 1'b0});
    vq.push_back('{1'b0, 1'b1, 1'b0, 4'd1,  4'd0,  5'd1, 4'd0,  4'd0,  1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b0, 1'b0, 1'b0, 4'd0,  4'd0,  5'd1, 4'd0,  4'd0,  1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b0, 1'b0, 1'b1, 4'd0,  4'd0,  5'd0, 4'd1,  4'd0,  1'b0, 1'b1, 1'b0});
    vq.push_back('{1'b0, 1'b0, 1'b0, 4'd0,  4'd0,  5'd0, 4'd1,  4'd0,  1'b0, 1'b1, 1'b0});
    vq.push_back('{1'b0, 1'b1, 1'b0, 4'd1,  4'd2,  5'd1, 4'd1,  4'd0,  1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b0, 1'b1, 1'b0, 4'd3,  4'd4,  5'd2, 4'd1,  4'd0,  1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b0, 1'b1, 1'b0, 4'd5,  4'd6,  5'd3, 4'd1,  4'd0,  1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b0, 1'b0, 1'b1, 4'd0,  4'd0,  5'd2, 4'd5,  4'd6,  1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b0, 1'b0, 1'b1, 4'd0,  4'd0,  5'd1, 4'd3,  4'd4,  1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b0, 1'b0, 1'b1, 4'd0,  4'd0,  5'd0, 4'd1,  4'd2,  1'b0, 1'b1, 1'b0});
    vq.push_back('{1'b0, 1'b0, 1'b1, 4'd0,  4'd0,  5'd0, 4'd1,  4'd2,  1'b1, 1'b1, 1'b0});
    vq.push_back('{1'b0, 1'b0, 1'b0, 4'd0,  4'd0,  5'd0, 4'd1,  4'd2,  1'b0, 1'b1, 1'b0});
    vq.push_back('{1'b1, 1'b0, 1'b0, 4'd0,  4'd0,  5'd0, 4'd0,  4'd0,  1'b0, 1'b1, 1'b0});
    vq.push_back('{1'b0, 1'b0, 1'b1, 4'd0,  4'd0,  5'd0, 4'd0,  4'd0,  1'b1, 1'b1, 1'b0});
    vq.push_back('{1'b0, 1'b0, 1'b0, 4'd0,  4'd0,  5'd0, 4'd0,  4'd0,  1'b0, 1'b1, 1'b0});
    vq.push_back('{1'b0, 1'b1, 1'b0, 4'd7,  4'd8,  5'd1, 4'd0,  4'd0,  1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b0, 1'b1, 1'b0, 4'd9,  4'd10, 5'd2, 4'd0,  4'd0,  1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b0, 1'b1, 1'b1, 4'd15, 4'd15, 5'd2, 4'd0,  4'd0,  1'b1, 1'b0, 1'b0});
    vq.push_back('{1'b0, 1'b0, 1'b1, 4'd0,  4'd0,  5'd1, 4'd9,  4'd10, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b0, 1'b1, 1'b0, 4'd11, 4'd12, 5'd2, 4'd9,  4'd10, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b0, 1'b0, 1'b1, 4'd0,  4'd0,  5'd1, 4'd11, 4'd12, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b1, 1'b1, 1'b0, 4'd2,  4'd3,  5'd0, 4'd0,  4'd0,  1'b0, 1'b1, 1'b0});
    vq.push_back('{1'b0, 1'b0, 1'b1, 4'd0,  4'd0,  5'd0, 4'd0,  4'd0,  1'b1, 1'b1, 1'b0});
    vq.push_back('{1'b0, 1'b0, 1'b0, 4'd0,  4'd0,  5'd0, 4'd0,  4'd0,  1'b0, 1'b1, 1'b0});

    @(negedge clk);
    foreach (vq[i]) begin
      step(vq[i].rst, vq[i].push, vq[i].pop, vq[i].x, vq[i].y);
      check_all($sformatf("vec%0d", i), int'(vq[i].e_count), int'(vq[i].e_x),
                int'(vq[i].e_y), vq[i].e_fail, vq[i].e_empty, vq[i].e_full);
    end

    // Fill to DEPTH with (i,15-i); last popped value is still (0,0).
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 1'b0, 4'(i), 4'(15 - i));
      check_all($sformatf("fill%0d", i), i + 1, 0, 0, 1'b0, 1'b0, (i == 15));
    end
    // Overflow must not disturb storage, count or outputs.
    step(1'b0, 1'b1, 1'b0, 4'd10, 4'd10);
    check_all("overflow", 16, 0, 0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    check_all("ovf_idle", 16, 0, 0, 1'b0, 1'b0, 1'b1);
    // Drain: LIFO order (15,0) down to (0,15).
    for (int k = 0; k < 16; k++) begin
      step(1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
      check_all($sformatf("drain%0d", k), 15 - k, 15 - k, k, 1'b0, (k == 15), 1'b0);
    end

    // Underflow followed by valid traffic, then reset with entries present.
    step(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    check_all("s_rst", 0, 0, 0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
    check_all("s_under", 0, 0, 0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 4'd4, 4'd5);
    check_all("s_push", 1, 0, 0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
    check_all("s_pop", 0, 4, 5, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 4'(i + 6), 4'(i + 1));
      check_all($sformatf("s_fill%0d", i), i + 1, 4, 5, 1'b0, 1'b0, 1'b0);
    end
    step(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    check_all("s_rst3", 0, 0, 0, 1'b0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stack.md
STACK -- requirements
Module: stack

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, giving the number of entries (legal range 2..256).
REQ-002 The block SHALL have parameter XW, default 4, giving the width of the x field.
REQ-003 The block SHALL have parameter YW, default 4, giving the width of the y field.
REQ-004 The block SHALL have port clk, input, 1 bit, as its single clock; all state changes on the rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, as its reset; reset is synchronous and active-high.
REQ-006 The block SHALL have port push, input, 1 bit, as the push request, sampled on each rising edge.
REQ-007 The block SHALL have port pop, input, 1 bit, as the pop request, sampled on each rising edge.
REQ-008 The block SHALL have port xIn, input, XW bits, as the x field of the entry to push.
REQ-009 The block SHALL have port yIn, input, YW bits, as the y field of the entry to push.
REQ-010 The block SHALL have port xOut, output, XW bits, registered, as the x field of the last popped entry.
REQ-011 The block SHALL have port yOut, output, YW bits, registered, as the y field of the last popped entry.
REQ-012 The block SHALL have port fail, output, 1 bit, registered, as the illegal-operation flag.
REQ-013 The block SHALL have port empty, output, 1 bit, combinational from count, high when count==0.
REQ-014 The block SHALL have port full, output, 1 bit, combinational from count, high when count==DEPTH.
REQ-015 The block SHALL have port count, output, clog2(DEPTH+1) bits, registered, as the number of stored entries.

Function
REQ-016 Storage SHALL be LIFO; each entry is the pair {x,y}, and push/pop act only on the top-of-stack index (count).
REQ-017 For push=1, pop=0 and not full, the block SHALL write {xIn,yIn} at index count and increment count on that edge; xOut/yOut hold.
REQ-018 For pop=1, push=0 and not empty, the block SHALL load xOut/yOut from entry count-1 and decrement count on that edge, i.e. popped data is visible the cycle after the pop request.
REQ-019 Push while full SHALL be an overflow: storage, count, xOut and yOut are unchanged and fail is set on that edge.
REQ-020 Pop while empty SHALL be an underflow: count, xOut and yOut are unchanged and fail is set on that edge.
REQ-021 push=1 together with pop=1 SHALL be illegal: no state changes and fail is set, regardless of full/empty.
REQ-022 With push=0 and pop=0 the block SHALL change no state; xOut/yOut SHALL hold their last popped value indefinitely.
REQ-023 Successful operations SHALL never set fail; in pulse mode (REQ-027) fail SHALL be 1 only in the cycle after an illegal request.
REQ-024 Entries popped and later overwritten SHALL return the newest pushed data; stale contents above the top SHALL never be observable.

Reset
REQ-025 When rst=1 at a rising edge, the block SHALL set count=0, xOut=0, yOut=0 and fail=0, overriding any push/pop in the same cycle; storage contents need not be cleared.
REQ-026 Reset asserted mid-sequence SHALL discard all entries, so that the first pop afterwards is an underflow.

Configuration
REQ-027 Without macro STACK_STICKY_FAIL_EN defined, fail SHALL be a one-cycle pulse per illegal request (high for exactly the cycle after each illegal edge).
REQ-028 With STACK_STICKY_FAIL_EN defined, fail SHALL stay at 1 after the first illegal request until rst; stack operation otherwise continues per REQ-017..REQ-022.

Verification
REQ-029 Reset, then push (x=1,y=0), idle one cycle, then pop -> count 1 then 0, xOut=1, yOut=0 the cycle after the pop, fail=0 throughout.
REQ-030 Push (1,2),(3,4),(5,6), then 3 pops -> xOut/yOut sequence (5,6),(3,4),(1,2), then empty=1.
REQ-031 Pop after reset -> fail=1 for one cycle, xOut=yOut=0, count=0.
REQ-032 16 pushes of (i,15-i), then one more push -> full=1 and fail pulse; then 16 pops return (15,0) down to (0,15).
REQ-033 push=pop=1 with count=2 -> fail=1, count stays 2, xOut/yOut unchanged.
REQ-034 With STACK_STICKY_FAIL_EN defined: underflow then a valid push/pop -> fail stays 1 until rst, data is still correct; rst during count=3 -> count=0, fail=0.
